// File: rtl/conv_pkg.sv
// Shared conv-datapath definitions: problem geometry, memory map defaults,
// writeback FSM states and a counter-width helper.
package conv_pkg;

   localparam int IMG_H      = 5;
   localparam int IMG_W      = 5;
   localparam int IMG_C      = 1;
   localparam int FILTER_H   = 3;
   localparam int FILTER_W   = 3;
   localparam int FILTER_NUM = 7;

   localparam int CONV_M = IMG_H * IMG_W;
   localparam int CONV_N = FILTER_H * FILTER_W * IMG_C;
   localparam int CONV_K = FILTER_NUM;

   localparam logic [31:0] DEF_IMG_BASE    = 32'h0000_0000;
   localparam logic [31:0] DEF_WEIGHT_BASE = 32'h0000_1000;
   localparam logic [31:0] DEF_IM2COL_BASE = 32'h0000_2000;
   localparam logic [31:0] DEF_OUTPUT_BASE = 32'h0000_3000;

   typedef enum logic [1:0] {
      WB_IDLE   = 2'd0,
      WB_WRITE  = 2'd1,
      WB_FINISH = 2'd2
   } wb_state_t;

   // Counter width that stays at least one bit wide for degenerate sizes.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/output_writeback_if.sv
// Word-addressed memory write port with a ready handshake.
interface output_writeback_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] addr_wr;
   logic [DATA_WIDTH-1:0] data_wr;
   logic                  wr_ready;

   modport master (
      output mem_wr_en,
      output addr_wr,
      output data_wr,
      input  wr_ready
   );

   modport slave (
      input  mem_wr_en,
      input  addr_wr,
      input  data_wr,
      output wr_ready
   );

endinterface

// File: rtl/wb_addr_gen.sv
// Beat index, (row, col) tracking and incrementing write address for the
// output writeback stage.
module wb_addr_gen
   import conv_pkg::*;
#(
   parameter int                    M           = CONV_M,
   parameter int                    K           = CONV_K,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(DEF_OUTPUT_BASE),
   localparam int                   IW          = cnt_width(M * K)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  advance,
   input  logic                  clear,
   output logic [IW-1:0]         idx_nxt,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   localparam int RW = cnt_width(M);
   localparam int CW = cnt_width(K);

   logic [IW-1:0] idx;
   logic [RW-1:0] row;
   logic [CW-1:0] col;

   assign idx_nxt = idx + IW'(1);
   assign last    = (row == RW'(M - 1)) && (col == CW'(K - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx  <= '0;
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (load) begin
         idx  <= '0;
         row  <= '0;
         col  <= '0;
         addr <= OUTPUT_BASE;
      end else if (advance) begin
         idx  <= idx_nxt;
         addr <= addr + ADDR_WIDTH'(1);
         if (col == CW'(K - 1)) begin
            col <= '0;
            row <= row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end else if (clear) begin
         idx <= '0;
         row <= '0;
         col <= '0;
      end
   end

endmodule

// File: rtl/output_writeback.sv
// Snapshots the systolic result vector on start and streams it, one word per
// accepted handshake, into memory at OUTPUT_BASE + i*K + j with optional ReLU.
module output_writeback
   import conv_pkg::*;
#(
   parameter int                    M           = CONV_M,
   parameter int                    K           = CONV_K,
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = ADDR_WIDTH'(DEF_OUTPUT_BASE),
   parameter bit                    RELU_EN     = 1'b0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [DATA_WIDTH*M*K-1:0]      Y,
   output_writeback_if.master             wr,
   output logic                           busy,
   output logic                           done
);

   localparam int NUM = M * K;
   localparam int IW  = cnt_width(NUM);

   wb_state_t             state, state_nxt;
   logic                  load, advance, clear, last;
   logic                  en_nxt, busy_nxt, done_nxt;
   logic [IW-1:0]         idx_nxt;
   logic [DATA_WIDTH-1:0] snap [NUM];

   function automatic logic [DATA_WIDTH-1:0] post(input logic [DATA_WIDTH-1:0] x);
      return (RELU_EN && x[DATA_WIDTH-1]) ? '0 : x;
   endfunction

   wb_addr_gen #(
      .M           (M),
      .K           (K),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .OUTPUT_BASE (OUTPUT_BASE)
   ) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .advance (advance),
      .clear   (clear),
      .idx_nxt (idx_nxt),
      .addr    (wr.addr_wr),
      .last    (last)
   );

   // done/busy change on the final acceptance edge, so done is visible
   // during FINISH: exactly one cycle after the last beat.
   always_comb begin
      state_nxt = state;
      en_nxt    = wr.mem_wr_en;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      load      = 1'b0;
      advance   = 1'b0;
      clear     = 1'b0;
      case (state)
         WB_IDLE: begin
            if (start) begin
               load      = 1'b1;
               en_nxt    = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = WB_WRITE;
            end
         end
         WB_WRITE: begin
            if (wr.mem_wr_en && wr.wr_ready) begin
               if (last) begin
                  en_nxt    = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = WB_FINISH;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         WB_FINISH: begin
            clear     = 1'b1;
            state_nxt = WB_IDLE;
         end
         default: state_nxt = WB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= WB_IDLE;
         wr.mem_wr_en <= 1'b0;
         wr.data_wr   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         wr.mem_wr_en <= en_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
         if (load) begin
            wr.data_wr <= post(Y[DATA_WIDTH-1:0]);
         end else if (advance) begin
            wr.data_wr <= post(snap[idx_nxt]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         for (int unsigned e = 0; e < NUM; e++) begin
            snap[e] <= Y[e*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_output_writeback.sv
// Bench for output_writeback: queue-based model of the expected write stream
// for the default geometry, plus small instances for ReLU and the 1x1 case.
module tb_output_writeback;

   localparam int M   = 25;
   localparam int K   = 7;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int NUM = M * K;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, start, busy, done;
   logic [DW*NUM-1:0] y;
   logic              start_s, busy1, done1, busy_r, done_r, busy_n, done_n;
   logic [DW-1:0]     y1;
   logic [3*DW-1:0]   y3;

   output_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus   ();
   output_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1  ();
   output_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_r ();
   output_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_n ();

   output_writeback #(.M(M), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .OUTPUT_BASE(32'h0000_3000), .RELU_EN(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .Y(y), .wr(bus), .busy(busy), .done(done));

   output_writeback #(.M(1), .K(1), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .OUTPUT_BASE(32'h0000_0010), .RELU_EN(1'b0)) dut_one (
      .clk(clk), .rst_n(rst_n), .start(start_s), .Y(y1), .wr(bus1), .busy(busy1), .done(done1));

   output_writeback #(.M(1), .K(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .OUTPUT_BASE(32'h0000_3000), .RELU_EN(1'b1)) dut_relu (
      .clk(clk), .rst_n(rst_n), .start(start_s), .Y(y3), .wr(bus_r), .busy(busy_r), .done(done_r));

   output_writeback #(.M(1), .K(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .OUTPUT_BASE(32'h0000_3000), .RELU_EN(1'b0)) dut_raw (
      .clk(clk), .rst_n(rst_n), .start(start_s), .Y(y3), .wr(bus_n), .busy(busy_n), .done(done_n));

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];
   bit          done_due = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   // Model: a pending-writes queue filled from Y at an accepted start,
   // drained by handshakes; done is due on the cycle after it empties.
   task automatic model_edge();
      if (!rst_n) begin
         q_addr.delete();
         q_data.delete();
         done_due = 1'b0;
      end else if (q_addr.size() != 0) begin
         if (bus.wr_ready) begin
            void'(q_addr.pop_front());
            void'(q_data.pop_front());
            if (q_addr.size() == 0) done_due = 1'b1;
         end
      end else if (done_due) begin
         done_due = 1'b0;
      end else if (start) begin
         for (int e = 0; e < NUM; e++) begin
            q_addr.push_back(32'h0000_3000 + 32'(e));
            q_data.push_back(y[e*DW +: DW]);
         end
      end
   endtask

   task automatic compare();
      bit exp_en;
      exp_en = (q_addr.size() != 0);
      chk("wr_en", {63'd0, bus.mem_wr_en}, {63'd0, exp_en});
      chk("busy", {63'd0, busy}, {63'd0, exp_en});
      chk("done", {63'd0, done}, {63'd0, done_due});
      if (exp_en) begin
         chk("addr", {32'd0, bus.addr_wr}, {32'd0, q_addr[0]});
         chk("data", {32'd0, bus.data_wr}, {32'd0, q_data[0]});
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc++;
      compare();
   endtask

   task automatic fill_y(input logic [31:0] off);
      for (int e = 0; e < NUM; e++) y[e*DW +: DW] = 32'((e / K) * 16 + (e % K)) + off;
   endtask

   initial begin
      int done_at, busy_cnt, acc, last_acc;
      logic [3:0] pat;

      rst_n = 1'b0; start = 1'b0; start_s = 1'b0;
      y = '0; y1 = 32'hDEAD_BEEF;
      y3 = {32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFB};
      bus.wr_ready = 1'b1; bus1.wr_ready = 1'b1; bus_r.wr_ready = 1'b1; bus_n.wr_ready = 1'b1;
      step(); step();
      rst_n = 1'b1;
      chk("rst_en", {63'd0, bus.mem_wr_en}, 64'd0);
      chk("rst_addr", {32'd0, bus.addr_wr}, 64'd0);
      chk("rst_data", {32'd0, bus.data_wr}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_small_en", {63'd0, bus1.mem_wr_en | bus_r.mem_wr_en}, 64'd0);
      step();

      // Full stream, ready always high
      fill_y(32'h0);
      start = 1'b1; step(); start = 1'b0;
      done_at = -1; busy_cnt = 0;
      for (int k = 1; k <= 180; k++) begin
         if (k == 1) chk("t1_first_addr", {32'd0, bus.addr_wr}, 64'h3000);
         if (k == 9) begin
            chk("t1_addr8", {32'd0, bus.addr_wr}, 64'h3008);
            chk("t1_data8", {32'd0, bus.data_wr}, 64'h11);
         end
         if (k == 175) chk("t1_busy_last", {63'd0, busy}, 64'd1);
         if (k == 176) chk("t1_busy_done", {63'd0, busy}, 64'd0);
         if (busy) busy_cnt++;
         if (done && done_at < 0) done_at = k;
         step();
      end
      chk("t1_done_cycle", 64'(done_at), 64'd176);
      chk("t1_busy_cycles", 64'(busy_cnt), 64'd175);

      // Ready toggling 1,0,0,1
      fill_y(32'h200);
      start = 1'b1; step(); start = 1'b0;
      pat = 4'b1001; acc = 0; last_acc = -1; done_at = -1;
      for (int k = 1; k <= 1000 && done_at < 0; k++) begin
         bus.wr_ready = pat[k % 4];
         if (bus.mem_wr_en && bus.wr_ready) begin
            acc++;
            last_acc = k;
         end
         if (done) done_at = k;
         step();
      end
      bus.wr_ready = 1'b1;
      chk("t2_done_seen", {63'd0, done_at > 0}, 64'd1);
      chk("t2_accepted", 64'(acc), 64'd175);
      chk("t2_done_gap", 64'(done_at - last_acc), 64'd1);
      step();

      // Restart attempts during the stream and coincident with done
      fill_y(32'h1000);
      start = 1'b1; step(); start = 1'b0;
      for (int k = 1; k <= 185; k++) begin
         if (k == 51) begin
            fill_y(32'h5000);
            start = 1'b1;
         end else if (done) begin
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (k == 61) begin
            chk("t3_addr60", {32'd0, bus.addr_wr}, 64'h303C);
            chk("t3_data60", {32'd0, bus.data_wr}, 64'h1084);
         end
         if (k == 176) chk("t3_done", {63'd0, done}, 64'd1);
         if (k == 178) chk("t3_no_restart", {62'd0, bus.mem_wr_en, busy}, 64'd0);
         step();
      end
      start = 1'b0;

      // Reset mid-stream, then a fresh full run
      fill_y(32'h300);
      start = 1'b1; step(); start = 1'b0;
      for (int k = 1; k <= 110; k++) begin
         rst_n = (k == 101) ? 1'b0 : 1'b1;
         if (k == 102) chk("t4_after_rst", {61'd0, bus.mem_wr_en, busy, done}, 64'd0);
         step();
      end
      rst_n = 1'b1;
      fill_y(32'h0);
      start = 1'b1; step(); start = 1'b0;
      chk("t4_fresh_addr", {32'd0, bus.addr_wr}, 64'h3000);
      acc = 0; done_at = -1;
      for (int k = 1; k <= 300 && done_at < 0; k++) begin
         if (bus.mem_wr_en && bus.wr_ready) acc++;
         if (done) done_at = k;
         step();
      end
      chk("t4_done_seen", {63'd0, done_at > 0}, 64'd1);
      chk("t4_accepted", 64'(acc), 64'd175);

      // 1x1 geometry and ReLU on/off
      start_s = 1'b1; step(); start_s = 1'b0;
      chk("one_k1", {29'd0, bus1.mem_wr_en, busy1, done1, bus1.addr_wr}, {29'd0, 3'b110, 32'h10});
      chk("one_data", {32'd0, bus1.data_wr}, 64'hDEAD_BEEF);
      chk("relu_d0", {bus_r.addr_wr, bus_r.data_wr}, {32'h3000, 32'h0});
      chk("raw_d0", {bus_n.addr_wr, bus_n.data_wr}, {32'h3000, 32'hFFFF_FFFB});
      step();
      chk("one_k2", {61'd0, bus1.mem_wr_en, busy1, done1}, 64'b001);
      chk("relu_d1", {bus_r.addr_wr, bus_r.data_wr}, {32'h3001, 32'h7});
      chk("raw_d1", {bus_n.addr_wr, bus_n.data_wr}, {32'h3001, 32'h7});
      step();
      chk("one_k3", {63'd0, done1}, 64'd0);
      chk("relu_d2", {bus_r.addr_wr, bus_r.data_wr}, {32'h3002, 32'h0});
      chk("raw_d2", {bus_n.addr_wr, bus_n.data_wr}, {32'h3002, 32'h8000_0000});
      step();
      chk("k3_done", {60'd0, bus_r.mem_wr_en, done_r, bus_n.mem_wr_en, done_n}, 64'b0101);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
